// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two requesters.
// Arbitration latches the winner's operands, then holds them on the ALU
// ports for one cycle (or MUL_LAT cycles for a multiply). The ALU result and
// zero flag are captured and returned through a valid/ready handshake.
// Only one operation is in flight at a time.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN so that requester 0 always wins
// a tie. When it is undefined, ties alternate (round-robin on last_grant).
module alu_arbiter #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [3:0]  req0_ctrl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [3:0]  req1_ctrl,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [15:0] resp_result,
    output logic        resp_zero,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_control,
    input  logic [15:0] alu_result,
    input  logic        alu_zero
);

    localparam logic [3:0] CTRL_MUL = 4'b1101;
    // Count is loaded with the number of extra EXEC cycles a multiply needs.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic [3:0]  op_ctrl_q, op_ctrl_d;
    logic [15:0] result_q, result_d;
    logic        zero_q, zero_d;

    logic [1:0]  req_valid_vec;
    logic [1:0]  req_ready_vec;
    logic [1:0]  resp_ready_vec;
    logic [1:0]  resp_valid_vec;
    logic        grant_valid;
    logic        grant_id;
    logic        accept;
    logic        resp_take;
    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [3:0]  sel_ctrl;

    assign req_valid_vec  = {req1_valid, req0_valid};
    assign resp_ready_vec = {resp1_ready, resp0_ready};

    // Grant select: a lone requester wins; a tie goes by priority policy.
    always_comb begin
        grant_valid = |req_valid_vec;
        grant_id    = 1'b0;
        case (req_valid_vec)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11:   grant_id = 1'b0;
`else
            2'b11:   grant_id = ~last_grant_q;
`endif
            default: grant_id = 1'b0;
        endcase
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a    = grant_id ? req1_a    : req0_a;
        sel_b    = grant_id ? req1_b    : req0_b;
        sel_ctrl = grant_id ? req1_ctrl : req0_ctrl;
    end

    assign accept    = (state_q == IDLE) && grant_valid;
    assign resp_take = (state_q == RESP) && resp_ready_vec[owner_q];

    // Per-requester handshake outputs. Ready is suppressed while reset is
    // asserted so nothing looks accepted during reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);
            assign req_ready_vec[gi]  = (state_q == IDLE) && grant_valid &&
                                        (grant_id == PORT_ID) && !rst;
            assign resp_valid_vec[gi] = (state_q == RESP) && (owner_q == PORT_ID);
        end
    endgenerate

    assign req0_ready  = req_ready_vec[0];
    assign req1_ready  = req_ready_vec[1];
    assign resp0_valid = resp_valid_vec[0];
    assign resp1_valid = resp_valid_vec[1];
    assign resp_result = result_q;
    assign resp_zero   = zero_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP when the hold
    // count runs out, RESP -> IDLE on the owner's response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: if (count_q == 4'd0) state_d = RESP;
            RESP: if (resp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU drive: operands are presented only during EXEC, zero otherwise.
    always_comb begin
        alu_a       = 8'h00;
        alu_b       = 8'h00;
        alu_control = 4'h0;
        if (state_q == EXEC) begin
            alu_a       = op_a_q;
            alu_b       = op_b_q;
            alu_control = op_ctrl_q;
        end
    end

    // Datapath next values: latch on accept, count down in EXEC, capture
    // the ALU outputs on the last EXEC cycle and hold them through RESP.
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctrl_d    = op_ctrl_q;
        result_d     = result_q;
        zero_d       = zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    op_a_d       = sel_a;
                    op_b_d       = sel_b;
                    op_ctrl_d    = sel_ctrl;
                    count_d      = (sel_ctrl == CTRL_MUL) ? MUL_LOAD : 4'd0;
                end
            end
            EXEC: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    result_d = alu_result;
                    zero_d   = alu_zero;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; last_grant resets to 1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            count_q      <= 4'd0;
            op_a_q       <= 8'h00;
            op_b_q       <= 8'h00;
            op_ctrl_q    <= 4'h0;
            result_q     <= 16'h0000;
            zero_q       <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctrl_q    <= op_ctrl_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between two requesters, requester 0 and requester 1, typically the execute stage and an address/branch helper.
- Arbitrates requests, latches operands and drives the ALU input ports.
- Holds the operands for a configurable number of cycles on multiply, captures the result and zero flag, and returns them with a valid/ready handshake.
- Only one operation is in flight at a time; there is no pipelining.

Parameters:
MUL_LAT, 2, number of EXEC cycles for a multiply (control 4'b1101); legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  8  operand a
req0_b  input  8  operand b
req0_ctrl  input  4  ALU control code
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  8  operand a
req1_b  input  8  operand b
req1_ctrl  input  4  ALU control code
resp0_valid  output  1  result for requester 0 available
resp0_ready  input  1  requester 0 takes the result
resp1_valid  output  1  result for requester 1 available
resp1_ready  input  1  requester 1 takes the result
resp_result  output  16  captured ALU result
resp_zero  output  1  captured ALU zero flag
alu_a  output  8  to ALU operand a
alu_b  output  8  to ALU operand b
alu_control  output  4  to ALU control
alu_result  input  16  from ALU result
alu_zero  input  1  from ALU zero flag

Behaviour:
- **Reset.** rst high forces, immediately and asynchronously:
  - state IDLE, owner 0, last_grant 1 (requester 0 wins first), count 0;
  - operand registers, resp_result and resp_zero at 0;
  - all ready and valid outputs at 0.
- **State IDLE.**
  - Grant select: if exactly one reqN_valid is high, grant N. If both are high, grant the requester that is not last_grant. If neither, no grant.
  - reqN_ready is combinational and is 1 only in IDLE for the granted N.
  - On an edge with valid & ready: latch a, b and ctrl into the operand registers, set owner = N and last_grant = N. Load count = MUL_LAT-1 if ctrl == 4'b1101, else 0. Go to EXEC.
  - The grant is recomputed every IDLE cycle. A requester dropping valid before acceptance loses nothing and locks nothing.
- **State EXEC.**
  - alu_a, alu_b and alu_control are driven from the operand registers; these ALU outputs are 0 in all other states.
  - If count != 0: decrement and stay in EXEC.
  - If count == 0: capture alu_result into resp_result and alu_zero into resp_zero, then go to RESP.
- **State RESP.**
  - resp{owner}_valid is 1; the other resp valid is 0.
  - resp_result and resp_zero stay stable until the handshake.
  - On resp{owner}_valid & resp{owner}_ready, go to IDLE.
  - No new request is accepted while in EXEC or RESP.
- **Latency.** With acceptance in cycle 0:
  - non-multiply: EXEC in cycle 1, resp_valid in cycle 2;
  - multiply: EXEC in cycles 1..MUL_LAT, resp_valid in cycle MUL_LAT+1.
- **Throughput.** The earliest next acceptance is the cycle after the response handshake, so a non-multiply op repeats at most every 3 cycles.
- **Unsupported control codes.** They pass through unchanged. The ALU returns 0, so resp_result is 0 and resp_zero is 1.
- **Widths.** Arithmetic is done entirely by the ALU. The arbiter does no extension or truncation; resp_result is the full 16 bits.
- **Reset during EXEC or RESP.** The operation is dropped and no resp_valid is ever produced for it. Requesters must re-issue.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- Defined: fixed priority. Requester 0 always wins when both are valid, and last_grant is ignored.
- Undefined: round-robin as specified in Behaviour.

Test Plan:
1. rst pulse during idle and during a multiply in EXEC -> all outputs 0 immediately, state IDLE; no resp_valid follows the aborted op.
2. req0 a=8'h05 b=8'h03 ctrl=4'b0010 -> req0_ready in cycle 0, alu_a=8'h05 in cycle 1, resp0_valid in cycle 2 with resp_result=16'h0008 and resp_zero=0.
3. MUL_LAT=2, req1 a=8'hFF b=8'hFF ctrl=4'b1101 -> alu_control=4'b1101 in cycles 1-2, resp1_valid in cycle 3 with resp_result=16'hFE01.
4. Both requesters continuously valid with adds, resp_ready tied 1 -> grant order 0,1,0,1 after reset; with ALU_ARB_FIXED_PRIO_EN defined, 0,0,0,0.
5. resp0_ready held low 5 cycles while req1_valid is high -> resp0_valid and resp_result held stable, req1_ready stays 0; req1 is accepted the cycle after the resp0 handshake.
6. req0 a=8'h07 b=8'h07 ctrl=4'b0110 -> resp_result=16'h0000 and resp_zero=1; ctrl=4'b1111 -> resp_result=0 and resp_zero=1.
